chunk_scheduler: RTL and testbench

//  Sequences one colorloop rasteriser unit through a frame. On frame_start it pulses
//  new_frame so colorloop clears the z-buffer, then accepts triangles from the setup

---
 rtl/chunk_scheduler.sv | 95 +++++++++
 tb/tb_chunk_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/chunk_scheduler.sv
// chunk_scheduler: runs colorloop over each triangle's CHUNK_SIZE-row bands, one band per color_en/done/all_done round
module chunk_scheduler #(
    parameter int SCREEN_H   = 480,
    parameter int CHUNK_SIZE = 16,
    parameter int Y_W        = 10,
    parameter int BAND_W     = 5
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              frame_start,
    input  logic              tri_valid,
    output logic              tri_ready,
    input  logic [Y_W-1:0]    tri_ymin,
    input  logic [Y_W-1:0]    tri_ymax,
    input  logic              tri_last,
    input  logic              cl_ready,
    input  logic              cl_done,
    output logic              cl_new_frame,
    output logic              cl_color_en,
    output logic [Y_W-1:0]    cl_height,
    output logic [BAND_W-1:0] cl_band,
    output logic              cl_all_done,
    output logic              frame_done,
    output logic              busy
);
    localparam int SH = $clog2(CHUNK_SIZE);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    typedef enum logic [3:0] {
        IDLE, CLR_REQ, CLR_HOLD, CLR_WAIT, FETCH, ISSUE, RUN, RELEASE, FRAME_END
    } state_t;

    state_t            state, state_nx;
    logic [BAND_W-1:0] band, last_band;
    logic [Y_W-1:0]    first_row;
    logic              last_flag;
    logic [Y_W-1:0]    ymax_c;
    logic              drop;
    logic              take;
    logic              more;

    assign ymax_c = tri_ymax > Y_MAX ? Y_MAX : tri_ymax;
    // ymax_c never exceeds Y_MAX, so this also rejects ymin beyond the screen
    assign drop   = tri_ymin > ymax_c;
    assign take   = state == FETCH && tri_valid;
    assign more   = band < last_band;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = frame_start ? CLR_REQ : IDLE;
            CLR_REQ:   state_nx = cl_ready ? CLR_HOLD : CLR_REQ;
            CLR_HOLD:  state_nx = CLR_WAIT;
            CLR_WAIT:  state_nx = cl_ready ? FETCH : CLR_WAIT;
            FETCH:     state_nx = !tri_valid ? FETCH : !drop ? ISSUE : tri_last ? FRAME_END : FETCH;
            ISSUE:     state_nx = cl_ready ? RUN : ISSUE;
            RUN:       state_nx = cl_done ? RELEASE : RUN;
            RELEASE:   state_nx = more ? ISSUE : last_flag ? FRAME_END : FETCH;
            FRAME_END: state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            band      <= '0;
            last_band <= '0;
            first_row <= '0;
            last_flag <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) last_flag <= tri_last;
            if (take && !drop) begin
                band      <= BAND_W'(tri_ymin >> SH);
                last_band <= BAND_W'(ymax_c >> SH);
                first_row <= tri_ymin & Y_W'(CHUNK_SIZE - 1);
            end
            // later bands of a triangle always start at row 0 of the band
            if (state == RELEASE && more) begin
                band      <= band + BAND_W'(1);
                first_row <= '0;
            end
        end
    end

    assign tri_ready    = state == FETCH;
    assign cl_new_frame = state == CLR_REQ && cl_ready;
    assign cl_color_en  = state == ISSUE && cl_ready;
    assign cl_all_done  = state == RELEASE;
    assign frame_done   = state == FRAME_END;
    assign busy         = state != IDLE;
    assign cl_height    = first_row;
    assign cl_band      = band;
endmodule

// File: tb/tb_chunk_scheduler.sv
// tb_chunk_scheduler: random triangle frames against a band-list model, with a behavioural colorloop responder
module tb_chunk_scheduler;
    logic       clk = 0, n_rst = 0;
    logic       fs_main = 0, fs_inj = 0, frame_start;
    logic       tri_valid = 0, tri_last = 0, cl_ready = 1, cl_done = 0;
    logic [9:0] tri_ymin = 0, tri_ymax = 0;
    logic       tri_ready, cl_new_frame, cl_color_en, cl_all_done, frame_done, busy;
    logic [9:0] cl_height;
    logic [4:0] cl_band;

    int checks = 0, errors = 0;
    int exp_q[$], obs_q[$];
    int nf_cnt = 0, ad_cnt = 0, fd_cnt = 0, clr_len = 4, last_band_obs = 0;
    bit clr_done = 0, inj_en = 0, tri_seen = 0;

    assign frame_start = fs_main | fs_inj;
    always #5 clk = ~clk;

    chunk_scheduler dut (
        .clk(clk), .n_rst(n_rst), .frame_start(frame_start),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_ymin(tri_ymin), .tri_ymax(tri_ymax),
        .tri_last(tri_last), .cl_ready(cl_ready), .cl_done(cl_done),
        .cl_new_frame(cl_new_frame), .cl_color_en(cl_color_en), .cl_height(cl_height),
        .cl_band(cl_band), .cl_all_done(cl_all_done), .frame_done(frame_done), .busy(busy)
    );

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // expected (band, start row) list for one triangle; returns 1 when it is dropped
    function automatic bit model(int ymin, int ymax);
        int ym;
        if (ymin >= 480) return 1;
        ym = ymax > 479 ? 479 : ymax;
        if (ymin > ym) return 1;
        for (int b = ymin / 16; b <= ym / 16; b++)
            exp_q.push_back(b * 1024 + (b == ymin / 16 ? ymin % 16 : 0));
        return 0;
    endfunction

    initial forever begin
        @(negedge clk);
        if (n_rst) begin
            if (cl_new_frame || cl_color_en) check("nf_ce_excl", int'(cl_new_frame & cl_color_en), 0);
            if (cl_new_frame) nf_cnt++;
            if (cl_color_en) begin
                obs_q.push_back(int'(cl_band) * 1024 + int'(cl_height));
                last_band_obs = int'(cl_band);
            end
            if (cl_all_done) begin
                ad_cnt++;
                check("ad_band", int'(cl_band), last_band_obs);
            end
            if (frame_done) fd_cnt++;
            if (tri_ready && !tri_seen) begin
                tri_seen = 1;
                check("tri_ready_after_clr", int'(clr_done), 1);
            end
        end
    end

    initial begin
        int r;
        forever begin
            @(negedge clk);
            if (cl_new_frame) begin
                clr_done = 0;
                @(posedge clk); #1 cl_ready = 0;
                repeat (clr_len) @(posedge clk);
                #1 cl_ready = 1; clr_done = 1;
            end else if (cl_color_en) begin
                @(posedge clk); #1 cl_ready = 0; fs_inj = inj_en;
                r = $urandom_range(2, 6);
                repeat (r) begin @(posedge clk); #1 fs_inj = 0; end
                cl_done = 1;
                @(posedge clk); #1 cl_done = 0;
                for (int i = 0; i < 50; i++) begin @(negedge clk); if (cl_all_done) break; end
                repeat ($urandom_range(0, 2)) @(posedge clk);
                @(posedge clk); #1 cl_ready = 1;
            end
        end
    end

    task automatic send(int ymin, int ymax, bit last);
        bit dropped;
        dropped = model(ymin, ymax);
        @(posedge clk); #1 tri_valid = 1; tri_ymin = 10'(ymin); tri_ymax = 10'(ymax); tri_last = last;
        for (int i = 0; i < 3000; i++) begin @(negedge clk); if (tri_ready) break; end
        check("handshake", int'(tri_ready), 1);
        @(posedge clk); #1 tri_valid = 0;
        if (dropped && last) begin
            @(negedge clk);
            check("fd_next", int'(frame_done), 1);
        end
    endtask

    task automatic begin_frame(int clr);
        exp_q.delete(); obs_q.delete();
        nf_cnt = 0; ad_cnt = 0; fd_cnt = 0; tri_seen = 0; clr_len = clr;
        inj_en = 1'($urandom_range(0, 1));
        @(posedge clk); #1 fs_main = 1;
        @(posedge clk); #1 fs_main = 0;
    endtask

    task automatic end_frame();
        for (int i = 0; i < 5000; i++) begin @(posedge clk); if (fd_cnt > 0) break; end
        @(negedge clk);
        check("busy_idle", int'(busy), 0);
        check("fd_cnt", fd_cnt, 1);
        check("nf_cnt", nf_cnt, 1);
        check("issues", obs_q.size(), exp_q.size());
        check("ad_cnt", ad_cnt, exp_q.size());
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
            check("band_height", obs_q[k], exp_q[k]);
    endtask

    initial begin
        int n, kind, ymin, ymax;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_outs", int'({tri_ready, cl_new_frame, cl_color_en, cl_all_done, frame_done}), 0);
        check("rst_band_height", int'(cl_band) * 1024 + int'(cl_height), 0);
        @(posedge clk); #1 n_rst = 1;

        begin_frame(4);
        send(20, 50, 0);
        send(5, 3, 0);
        send(470, 600, 1);
        end_frame();

        begin_frame(2);
        send(500, 100, 1);
        end_frame();

        begin_frame(1);
        send(0, 15, 0);
        send(16, 16, 0);
        send(479, 479, 1);
        end_frame();

        for (int f = 0; f < 15; f++) begin
            begin_frame($urandom_range(1, 5));
            n = $urandom_range(1, 5);
            for (int t = 0; t < n; t++) begin
                kind = $urandom_range(0, 9);
                ymin = $urandom_range(0, 479);
                if (kind == 0) begin
                    ymin = $urandom_range(480, 1023); ymax = $urandom_range(0, 1023);
                end else if (kind == 1 && ymin > 0) begin
                    ymax = $urandom_range(0, ymin - 1);
                end else if (kind == 2) begin
                    ymax = $urandom_range(0, 1023);
                end else begin
                    ymax = ymin + $urandom_range(0, 60);
                end
                send(ymin, ymax, t == n - 1);
            end
            end_frame();
        end

        begin_frame(2);
        send(0, 200, 1);
        for (int i = 0; i < 2000; i++) begin @(posedge clk); if (obs_q.size() >= 2) break; end
        @(posedge clk); #3 n_rst = 0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_outs", int'({tri_ready, cl_new_frame, cl_color_en, cl_all_done, frame_done}), 0);
        check("mid_rst_band_height", int'(cl_band) * 1024 + int'(cl_height), 0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
